token_sequencer: RTL and testbench

- Controller between the line tokenizer and the Forth parser.
- Paces the tokenizer's per-character next strobe and assembles characters into whitespace-delimited words.
- Hands each completed word to the parser over a valid/ack handshake and flags the end of each line.
- The parser consumes whole words, never raw characters.

---
 rtl/forth_pkg.sv | 23 ++
 rtl/token_sequencer_if.sv | 38 +++
 rtl/token_sequencer_word_buffer.sv | 51 +++++
 rtl/token_sequencer.sv | 125 ++++++++++++
 tb/tb_token_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forth_pkg.sv
// Shared Forth front-end types: character type, delimiter characters,
// the token sequencer state enum and the upcase() helper.
package forth_pkg;

  typedef logic [7:0] char_t;

  localparam char_t CHAR_EOL = 8'h0A;
  localparam char_t CHAR_WC  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_GAP,
    ST_EMIT
  } tokseq_state_t;

  function automatic char_t upcase(input char_t c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/token_sequencer_if.sv
// Tokenizer-side and parser-side signals of the token sequencer.
// Parser handshake: o_word_valid stays high with the word held stable until
// a cycle with i_word_ack=1 (and i_en=1); that cycle completes the transfer.
interface token_sequencer_if
  import forth_pkg::*;
#(
  parameter int WORD_LEN = 8,
  localparam int WLEN_BITS = $clog2(WORD_LEN + 1)
);

  char_t                 i_tok_data;
  logic                  i_tok_data_ready;
  logic                  i_tok_eol;
  logic                  i_tok_wc;
  logic                  o_tok_next;

  char_t                 o_word [WORD_LEN];
  logic [WLEN_BITS-1:0]  o_word_len;
  logic                  o_word_valid;
  logic                  o_word_eol;
  logic                  o_word_ovf;
  logic                  i_word_ack;

  modport master (
    input  i_tok_data, i_tok_data_ready, i_tok_eol, i_tok_wc,
    output o_tok_next,
    output o_word, o_word_len, o_word_valid, o_word_eol, o_word_ovf,
    input  i_word_ack
  );

  modport slave (
    output i_tok_data, i_tok_data_ready, i_tok_eol, i_tok_wc,
    input  o_tok_next,
    input  o_word, o_word_len, o_word_valid, o_word_eol, o_word_ovf,
    output i_word_ack
  );

endinterface

// File: rtl/token_sequencer_word_buffer.sv
// word_buffer: fixed-size character array with length count and a sticky
// overflow flag; characters beyond WORD_LEN are dropped and flagged.
module word_buffer
  import forth_pkg::*;
#(
  parameter int WORD_LEN = 8,
  localparam int WLEN_BITS = $clog2(WORD_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_store,
  input  logic                 i_clear,
  input  char_t                i_char,
  output char_t                o_word [WORD_LEN],
  output logic [WLEN_BITS-1:0] o_len,
  output logic                 o_ovf
);

  char_t                r_word [WORD_LEN];
  logic [WLEN_BITS-1:0] r_len;
  logic                 r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < WORD_LEN; k++) r_word[k] <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_len <= '0;
        r_ovf <= 1'b0;
        for (int k = 0; k < WORD_LEN; k++) r_word[k] <= '0;
      end else if (i_store) begin
        if (r_len < WLEN_BITS'(WORD_LEN)) begin
          for (int k = 0; k < WORD_LEN; k++) begin
            if (WLEN_BITS'(k) == r_len) r_word[k] <= i_char;
          end
          r_len <= r_len + WLEN_BITS'(1);
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign o_word = r_word;
  assign o_len  = r_len;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/token_sequencer.sv
// Paces the tokenizer one character per 3 cycles and hands whole words to
// the parser. Optional TOKSEQ_UPCASE_EN folds a..z to A..Z on store.
module token_sequencer
  import forth_pkg::*;
#(
  parameter int    WORD_LEN = 8,
  parameter char_t EOL      = CHAR_EOL,
  parameter char_t WC       = CHAR_WC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  token_sequencer_if.master  bus,
  output logic               o_busy,
  output tokseq_state_t      o_state
);

  tokseq_state_t r_state, w_next_state;
  logic          r_eol_seen, w_eol_seen_nxt;
  logic          r_word_eol, w_word_eol_nxt;
  logic          w_tok_next, w_store, w_clear;
  logic          w_is_eol, w_is_delim;
  char_t         w_char;

  // Accept either the tokenizer's flags or a direct character match.
  assign w_is_eol   = bus.i_tok_eol | (bus.i_tok_data == EOL);
  assign w_is_delim = w_is_eol | bus.i_tok_wc | (bus.i_tok_data == WC);

`ifdef TOKSEQ_UPCASE_EN
  assign w_char = upcase(bus.i_tok_data);
`else
  assign w_char = bus.i_tok_data;
`endif

  word_buffer #(.WORD_LEN(WORD_LEN)) u_word_buffer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_store (w_store),
    .i_clear (w_clear),
    .i_char  (w_char),
    .o_word  (bus.o_word),
    .o_len   (bus.o_word_len),
    .o_ovf   (bus.o_word_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_eol_seen <= 1'b0;
      r_word_eol <= 1'b0;
    end else if (i_en) begin
      r_state    <= w_next_state;
      r_eol_seen <= w_eol_seen_nxt;
      r_word_eol <= w_word_eol_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_eol_seen_nxt = r_eol_seen;
    w_word_eol_nxt = r_word_eol;
    w_tok_next     = 1'b0;
    w_store        = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_tok_data_ready) begin
          w_next_state   = ST_FETCH;
          w_eol_seen_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        if (!bus.i_tok_data_ready) begin
          if (r_eol_seen) begin
            w_next_state = ST_IDLE;
          end else begin
            w_word_eol_nxt = 1'b1;
            w_next_state   = ST_EMIT;
          end
        end else begin
          w_tok_next   = 1'b1;
          w_next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // After the line's EOL the remaining characters are only drained.
        if (r_eol_seen) begin
          w_next_state = ST_GAP;
        end else if (w_is_delim) begin
          if (bus.o_word_len != '0 || w_is_eol) begin
            w_word_eol_nxt = w_is_eol;
            w_eol_seen_nxt = w_is_eol;
            w_next_state   = ST_EMIT;
          end else begin
            w_next_state = ST_GAP;
          end
        end else begin
          w_store      = 1'b1;
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        w_next_state = ST_FETCH;
      end
      ST_EMIT: begin
        if (bus.i_word_ack) begin
          w_clear        = 1'b1;
          w_word_eol_nxt = 1'b0;
          w_next_state   = (r_word_eol && !bus.i_tok_data_ready) ? ST_IDLE : ST_GAP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign bus.o_tok_next   = w_tok_next & i_en;
  assign bus.o_word_valid = (r_state == ST_EMIT);
  assign bus.o_word_eol   = r_word_eol;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_state          = r_state;

endmodule

// File: tb/tb_token_sequencer.sv
// Bench for token_sequencer: tokenizer model, word-level reference model
// with an expected queue, per-cycle compare process and directed checks.
module tb_token_sequencer;
  import forth_pkg::*;

  localparam int WL = 8;
  localparam int WB = $clog2(WL + 1);
  localparam int EW = 2 + WB + 8 * WL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic o_busy;
  tokseq_state_t st;

  always #5 clk = ~clk;

  token_sequencer_if #(.WORD_LEN(WL)) bus ();

  token_sequencer #(.WORD_LEN(WL)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .bus     (bus.master),
    .o_busy  (o_busy),
    .o_state (st)
  );

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  // ---------------- tokenizer model ----------------
  string tok_line = "";
  int    ptr = 0;
  logic  last = 1'b0;
  logic  load_req = 1'b0;
  logic  tok_ready = 1'b0;
  char_t tok_data = '0;
  logic  tok_eol = 1'b0;
  logic  tok_wc = 1'b0;

  assign bus.i_tok_data       = tok_data;
  assign bus.i_tok_data_ready = tok_ready;
  assign bus.i_tok_eol        = tok_eol;
  assign bus.i_tok_wc         = tok_wc;

  always @(posedge clk) begin
    if (load_req) begin
      ptr <= 0;
      last <= 1'b0;
      tok_ready <= 1'b1;
    end else if (bus.o_tok_next) begin
      tok_data <= tok_line[ptr];
      tok_eol  <= (tok_line[ptr] == CHAR_EOL);
      tok_wc   <= (tok_line[ptr] == CHAR_WC);
      ptr <= ptr + 1;
      if (ptr + 1 >= tok_line.len()) last <= 1'b1;
    end else if (last) begin
      tok_ready <= 1'b0;
      last <= 1'b0;
    end
  end

  // ---------------- ack driver ----------------
  int   ack_mode = 0;
  logic man_ack = 1'b0;

  always begin
    @(posedge clk);
    #2;
    case (ack_mode)
      0:       bus.i_word_ack = 1'b1;
      1:       bus.i_word_ack = ($urandom_range(0, 3) != 0);
      default: bus.i_word_ack = man_ack;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic chk(input bit ok, input string name, input logic [EW-1:0] act,
                     input logic [EW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_eq(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    chk(act == req, name, act, req);
  endtask

  function automatic logic [EW-1:0] dut_word();
    logic [EW-1:0] w;
    w = '0;
    for (int k = 0; k < WL; k++) w[8*k +: 8] = bus.o_word[k];
    w[8*WL +: WB] = bus.o_word_len;
    w[EW-2] = bus.o_word_ovf;
    w[EW-1] = bus.o_word_eol;
    return w;
  endfunction

  function automatic logic [EW-1:0] mask_w(input logic [EW-1:0] w);
    int n;
    n = int'(w[8*WL +: WB]);
    for (int k = 0; k < WL; k++) if (k >= n) w[8*k +: 8] = '0;
    return w;
  endfunction

  function automatic char_t fold(input char_t c);
`ifdef TOKSEQ_UPCASE_EN
    if (c >= "a" && c <= "z") return c - ("a" - "A");
`endif
    return c;
  endfunction

  function automatic logic [EW-1:0] pack(input char_t cs [WL], input int n, input bit ovf,
                                         input bit eol);
    logic [EW-1:0] w;
    w = '0;
    for (int k = 0; k < WL; k++) if (k < n) w[8*k +: 8] = cs[k];
    w[8*WL +: WB] = WB'(n);
    w[EW-2] = ovf;
    w[EW-1] = eol;
    return w;
  endfunction

  // Reference: split the line on spaces up to the first EOL; the word that
  // ends the line (at EOL or exhaustion) is always emitted, even if empty.
  task automatic model_line(input string s);
    char_t cs [WL];
    int n;
    bit ovf;
    char_t c;
    n = 0;
    ovf = 1'b0;
    for (int k = 0; k < WL; k++) cs[k] = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == CHAR_EOL) begin
        exp_q.push_back(pack(cs, n, ovf, 1'b1));
        return;
      end else if (c == CHAR_WC) begin
        if (n > 0) begin
          exp_q.push_back(pack(cs, n, ovf, 1'b0));
          n = 0;
          ovf = 1'b0;
        end
      end else if (n < WL) begin
        cs[n] = fold(c);
        n++;
      end else begin
        ovf = 1'b1;
      end
    end
    exp_q.push_back(pack(cs, n, ovf, 1'b1));
  endtask

  // ---------------- compare process ----------------
  logic          chk_on = 1'b0;
  logic          stab = 1'b0;
  logic [EW-1:0] prev_w = '0;
  int            n_next = 0;

  always @(negedge clk) begin
    logic [EW-1:0] cur, e;
    cur = dut_word();
    if (!rst && en && bus.o_tok_next) n_next++;
    if (chk_on && !rst) begin
      if (stab) chk_eq("hold_while_waiting", cur, prev_w);
      if (bus.o_word_valid) chk_eq("no_next_while_valid", EW'(bus.o_tok_next), '0);
      if (!en) chk_eq("no_next_while_disabled", EW'(bus.o_tok_next), '0);
      if (bus.o_word_valid && bus.i_word_ack && en) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", cur, '0);
        end else begin
          e = exp_q.pop_front();
          chk(mask_w(cur) == mask_w(e), "word", cur, e);
        end
        got_q.push_back(cur);
      end
      stab = bus.o_word_valid && !(bus.i_word_ack && en);
    end else begin
      stab = 1'b0;
    end
    prev_w = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_line(input string s);
    model_line(s);
    tok_line = s;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_word_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(seen, {"valid_timeout_", name}, EW'(seen), EW'(1));
  endtask

  task automatic wait_done(input string name, input bit rand_en);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rand_en) en = ($urandom_range(0, 7) != 0);
      tick();
      if (!tok_ready && !o_busy && exp_q.size() == 0 && !bus.o_word_valid) begin
        done = 1'b1;
        break;
      end
    end
    en = 1'b1;
    tick();
    chk(done, {"done_timeout_", name}, EW'(done), EW'(1));
  endtask

  function automatic string rand_line();
    string pool;
    string s;
    int n;
    pool = "ABXYZabqz019+-*   ";
    s = "";
    n = $urandom_range(1, 13);
    for (int i = 0; i < n; i++) begin
      s = {s, " "};
      s.putc(s.len() - 1, pool[$urandom_range(0, pool.len() - 1)]);
    end
    if ($urandom_range(0, 1) == 1) s.putc($urandom_range(0, n - 1), CHAR_EOL);
    return s;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int start_next;
    tokseq_state_t st_hold;

    rst = 1'b1;
    en = 1'b1;
    ack_mode = 0;
    repeat (3) tick();
    chk_eq("reset_word", dut_word(), '0);
    chk_eq("reset_valid", EW'(bus.o_word_valid), '0);
    chk_eq("reset_next", EW'(bus.o_tok_next), '0);
    chk_eq("reset_busy", EW'(o_busy), '0);
    rst = 1'b0;
    chk_on = 1'b1;
    tick();

    // One pulse per character, the terminator included.
    got_q.delete();
    start_next = n_next;
    load_line("DUP\n");
    wait_valid("dup");
    chk_eq("dup_next_pulses", EW'(n_next - start_next), EW'(4));
    wait_done("dup", 1'b0);
    chk_eq("dup_count", EW'(got_q.size()), EW'(1));
    if (got_q.size() > 0) chk_eq("dup_word", got_q[0], {1'b1, 1'b0, 4'd3, 64'h0000_0000_0050_5544});
    chk_eq("dup_idle", EW'(st), EW'(ST_IDLE));

    got_q.delete();
    ack_mode = 1;
    load_line("  1 2 +");
    wait_done("spaces", 1'b0);
    chk_eq("spaces_count", EW'(got_q.size()), EW'(3));
    if (got_q.size() == 3) begin
      chk_eq("spaces_w0", got_q[0], {1'b0, 1'b0, 4'd1, 64'h31});
      chk_eq("spaces_w1", got_q[1], {1'b0, 1'b0, 4'd1, 64'h32});
      chk_eq("spaces_w2", got_q[2], {1'b1, 1'b0, 4'd1, 64'h2B});
    end

    got_q.delete();
    load_line(" \n");
    wait_done("empty", 1'b0);
    chk_eq("empty_count", EW'(got_q.size()), EW'(1));
    if (got_q.size() > 0) chk_eq("empty_word", got_q[0], {1'b1, 1'b0, 4'd0, 64'h0});

    got_q.delete();
    load_line("A\nB");
    wait_done("after_eol", 1'b0);
    chk_eq("after_eol_count", EW'(got_q.size()), EW'(1));
    if (got_q.size() > 0) chk_eq("after_eol_word", got_q[0], {1'b1, 1'b0, 4'd1, 64'h41});
    chk_eq("after_eol_drained", EW'(ptr), EW'(3));

    got_q.delete();
    load_line("ABCDEFGHIJ\n");
    wait_done("ovf", 1'b0);
    chk_eq("ovf_count", EW'(got_q.size()), EW'(1));
    if (got_q.size() > 0) chk_eq("ovf_word", got_q[0], {1'b1, 1'b1, 4'd8, 64'h4847_4645_4443_4241});

    got_q.delete();
    load_line("dup\n");
    wait_done("case", 1'b0);
    chk_eq("case_count", EW'(got_q.size()), EW'(1));
`ifdef TOKSEQ_UPCASE_EN
    if (got_q.size() > 0) chk_eq("case_word", got_q[0], {1'b1, 1'b0, 4'd3, 64'h0000_0000_0050_5544});
`else
    if (got_q.size() > 0) chk_eq("case_word", got_q[0], {1'b1, 1'b0, 4'd3, 64'h0000_0000_0070_7564});
`endif

    // Parser stalls with the word presented, then a reset discards it.
    ack_mode = 2;
    man_ack = 1'b0;
    load_line("SWAP\n");
    wait_valid("swap");
    repeat (10) tick();
    chk_eq("swap_held", dut_word(), {1'b1, 1'b0, 4'd4, 64'h0000_0000_5041_5753});
    chk_eq("swap_state", EW'(st), EW'(ST_EMIT));
    rst = 1'b1;
    tick();
    chk_eq("rst_valid", EW'(bus.o_word_valid), '0);
    chk_eq("rst_state", EW'(st), EW'(ST_IDLE));
    rst = 1'b0;
    exp_q.delete();
    ack_mode = 1;
    tick();

    load_line("AB CD EF\n");
    repeat (7) tick();
    en = 1'b0;
    st_hold = st;
    repeat (5) begin
      tick();
      chk_eq("pause_state", EW'(st), EW'(st_hold));
    end
    en = 1'b1;
    wait_done("pause", 1'b0);

    for (int n = 0; n < 40; n++) begin
      load_line(rand_line());
      wait_done("random", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
